// File: rtl/fire_alarm_responder_pkg.sv
// Shared types and helpers for the fire alarm responder: zone count, FSM encoding,
// dispatch message header and the message-byte packer.
package fire_alarm_pkg;

  localparam int NUM_ZONES = 4;

  // 2'd3 is unused; the FSM steers it back to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALARM = 2'd1,
    ACKED = 2'd2
  } state_e;

  localparam logic [1:0] MSG_HEADER = 2'b10;

  function automatic logic [7:0] pack_msg(input logic call_seen,
                                          input logic escalated,
                                          input logic [NUM_ZONES-1:0] zones);
    return {MSG_HEADER, call_seen, escalated, zones};
  endfunction

endpackage

// File: rtl/fire_alarm_responder_if.sv
// Panel-side bundle: alarm/operator inputs, dispatch valid/ready link and indicator outputs.
// slave = the responder, master = whoever drives the panel inputs.
interface fire_alarm_responder_if;
  import fire_alarm_pkg::*;

  logic [NUM_ZONES-1:0] fire_alarm;
  logic                 call;
  logic                 ack;
  logic                 clear;
  logic                 dispatch_ready;
  logic                 dispatch_valid;
  logic [7:0]           dispatch_data;
  logic [NUM_ZONES-1:0] zone_latched;
  logic                 siren;
  logic                 strobe;
  logic [1:0]           state;

  modport master (
    output fire_alarm, call, ack, clear, dispatch_ready,
    input  dispatch_valid, dispatch_data, zone_latched, siren, strobe, state
  );

  modport slave (
    input  fire_alarm, call, ack, clear, dispatch_ready,
    output dispatch_valid, dispatch_data, zone_latched, siren, strobe, state
  );

endinterface

// File: rtl/fire_alarm_responder_dispatch_tx.sv
// Dispatch holding register: a trigger while idle loads the snapshot; a trigger while
// holding merges into one pending message issued after the transfer and one idle cycle.
module dispatch_tx (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger_i,
  input  logic [7:0] snapshot_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [7:0] data_o
);

  logic       valid_q, valid_d;
  logic       pending_q, pending_d;
  logic [7:0] data_q, data_d;

  always_comb begin
    valid_d   = valid_q;
    pending_d = pending_q;
    data_d    = data_q;
    if (valid_q) begin
      // Data stays frozen; the cycle after a transfer is always idle.
      if (trigger_i) pending_d = 1'b1;
      if (ready_i)   valid_d   = 1'b0;
    end else if (trigger_i || pending_q) begin
      valid_d   = 1'b1;
      data_d    = snapshot_i;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pending_q <= 1'b0;
      data_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      pending_q <= pending_d;
      data_q    <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fire_alarm_responder.sv
// Fire alarm responder: latches zones, drives siren/strobe, handles ack/clear, sends dispatch bytes.
// FIRE_RESP_REALERT_EN: newly latched zones in ACKED return the FSM to ALARM.
module fire_alarm_responder
  import fire_alarm_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1000,
  parameter int SIREN_HALF  = 50
) (
  input logic                  clk,
  input logic                  reset,
  fire_alarm_responder_if.slave bus
);

  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam int SW = $clog2(SIREN_HALF + 1);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(ACK_TIMEOUT - 1);
  localparam logic [SW-1:0] SIREN_LAST = SW'(SIREN_HALF - 1);

  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [SW-1:0]        sir_cnt_q, sir_cnt_d;
  logic                 siren_q, siren_d;
  logic                 strobe_q;
  logic                 escalated_q, escalated_d;
  logic                 sent_q, sent_d;
  logic                 call_seen_q, call_seen_d;
  logic [NUM_ZONES-1:0] zone_q, zone_d;
  logic                 new_zone, clear_ok, escalate, trigger;
  logic [7:0]           snapshot;

  always_comb begin
    new_zone    = |(bus.fire_alarm & ~zone_q);
    clear_ok    = (state_q == ACKED) && bus.clear && (bus.fire_alarm == '0) && !bus.call;
    state_d     = state_q;
    timer_d     = timer_q;
    sir_cnt_d   = sir_cnt_q;
    siren_d     = siren_q;
    escalated_d = escalated_q;
    escalate    = 1'b0;
    zone_d      = zone_q | bus.fire_alarm;
    call_seen_d = call_seen_q | bus.call;

    case (state_q)
      IDLE: begin
        if ((bus.fire_alarm != '0) || bus.call) begin
          state_d   = ALARM;
          timer_d   = '0;
          siren_d   = 1'b1;
          sir_cnt_d = '0;
        end
      end
      ALARM: begin
        if (bus.ack) begin
          state_d = ACKED;
          siren_d = 1'b0;
        end else begin
          if (timer_q != TIMER_MAX) timer_d = timer_q + 1'b1;
          if ((timer_q == TIMER_MAX) && !escalated_q) begin
            escalate    = 1'b1;
            escalated_d = 1'b1;
          end
          if (sir_cnt_q == SIREN_LAST) begin
            siren_d   = ~siren_q;
            sir_cnt_d = '0;
          end else begin
            sir_cnt_d = sir_cnt_q + 1'b1;
          end
        end
      end
      ACKED: begin
        siren_d = 1'b0;
        if (clear_ok) begin
          state_d     = IDLE;
          zone_d      = '0;
          escalated_d = 1'b0;
          call_seen_d = 1'b0;
        end
`ifdef FIRE_RESP_REALERT_EN
        else if (new_zone) begin
          state_d   = ALARM;
          timer_d   = '0;
          siren_d   = 1'b1;
          sir_cnt_d = '0;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        siren_d = 1'b0;
      end
    endcase

    // Call only triggers until a message has gone out; afterwards new zones send updates.
    trigger  = (bus.call && !sent_q) || escalate || (sent_q && new_zone);
    sent_d   = (sent_q && !clear_ok) || trigger;
    snapshot = pack_msg(call_seen_d, escalated_d, zone_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      sir_cnt_q   <= '0;
      siren_q     <= 1'b0;
      strobe_q    <= 1'b0;
      escalated_q <= 1'b0;
      sent_q      <= 1'b0;
      call_seen_q <= 1'b0;
      zone_q      <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      sir_cnt_q   <= sir_cnt_d;
      siren_q     <= siren_d;
      strobe_q    <= (state_d != IDLE);
      escalated_q <= escalated_d;
      sent_q      <= sent_d;
      call_seen_q <= call_seen_d;
      zone_q      <= zone_d;
    end
  end

  dispatch_tx u_tx (
    .clk        (clk),
    .reset      (reset),
    .trigger_i  (trigger),
    .snapshot_i (snapshot),
    .ready_i    (bus.dispatch_ready),
    .valid_o    (bus.dispatch_valid),
    .data_o     (bus.dispatch_data)
  );

  assign bus.zone_latched = zone_q;
  assign bus.siren        = siren_q;
  assign bus.strobe       = strobe_q;
  assign bus.state        = state_q;

endmodule

// File: doc/fire_alarm_responder.md
Name: fire_alarm_responder

Overview:
- Panel-side responder for the zone alarm outputs (fire_alarm[3:0]) and the fire-department call line (call) produced by fire_alarm_system.
- Latches alarmed zones and drives a pulsed siren and a strobe.
- Handles operator acknowledge and clear.
- Sends a one-byte dispatch message over a valid/ready link when call asserts or the alarm goes unacknowledged too long.

Parameters:
- ACK_TIMEOUT, 1000: cycles in ALARM without ack before escalation (min 2).
- SIREN_HALF, 50: siren half-period in cycles (min 1).

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  asynchronous, active-high
- fire_alarm  input  4  per-zone alarm, synchronous to clk
- call  input  1  heat-confirmed call request, synchronous to clk
- ack  input  1  operator acknowledge, one-cycle or level
- clear  input  1  operator panel reset
- dispatch_ready  input  1  link accepts message
- dispatch_valid  output  1  message available
- dispatch_data  output  8  message byte
- zone_latched  output  4  sticky zone record
- siren  output  1  audible output, pulsed
- strobe  output  1  visual output
- state  output  2  current FSM state

Behaviour:
- Reset (async, active-high) clears all outputs and internal registers: state=IDLE, siren=0, strobe=0, zone_latched=0, dispatch_valid=0, dispatch_data=0, timer=0, escalated=0, sent=0, pending=0.
- All outputs are registered. Decisions use inputs sampled at edge N; results are visible after edge N.
- zone_latched:
  - Each edge, zone_latched <= zone_latched | fire_alarm.
  - An accepted clear instead sets it to 0.
- IDLE -> ALARM when fire_alarm != 0 or call=1. On entry: timer=0, siren=1, siren phase counter=0.
- ALARM:
  - siren toggles every SIREN_HALF cycles (high for the first SIREN_HALF cycles).
  - timer increments once per cycle.
  - When timer reaches ACK_TIMEOUT-1 with ack=0, escalated=1 and a dispatch is triggered (once per event).
  - ack=1 -> ACKED. ack wins over a same-edge timeout: no escalation.
- ACKED:
  - siren=0, timer frozen.
  - clear=1 and fire_alarm==0 and call==0 -> IDLE; zone_latched, escalated and sent cleared.
  - clear with any zone or call active is ignored.
- strobe=1 whenever state != IDLE.
- ack outside ALARM is ignored. clear outside ACKED is ignored.
- Dispatch triggers:
  - call=1 sampled in any state, while sent=0.
  - The timeout escalation.
  - After sent=1: any edge where zone_latched gains a new bit (update message).
  - Call held high does not retrigger once sent=1.
- Message format:
  - dispatch_data = {2'b10, call_seen, escalated, zone_latched}, snapshot at issue.
  - call_seen is a sticky flag of call since the last clear.
- Handshake:
  - Trigger with dispatch_valid=0 -> dispatch_valid=1 next cycle, sent=1.
  - data is frozen while valid=1. Transfer occurs at an edge with valid & ready.
  - valid then drops to 0 for at least one cycle.
  - A trigger while valid=1 sets pending. After the transfer, one idle cycle, then a fresh snapshot is issued and pending is cleared.
  - Multiple triggers merge into one pending message.
- clear never aborts a held message; valid stays high until accepted.
- Counter widths:
  - timer is $clog2(ACK_TIMEOUT) bits and saturates at ACK_TIMEOUT-1.
  - The siren counter is $clog2(SIREN_HALF+1) bits and wraps to 0 on toggle.
- Reset mid-message drops the message (valid=0 immediately).

Optional Feature:
- Macro: FIRE_RESP_REALERT_EN.
- Defined: in ACKED, any newly latched zone bit returns the FSM to ALARM. timer and siren phase restart; escalation may fire again only if escalated=0.
- Undefined: new zones in ACKED only latch and trigger an update dispatch (if sent=1); siren stays silent.

Decomposition:
- Package fire_alarm_pkg:
  - NUM_ZONES=4.
  - State encoding IDLE=2'd0, ALARM=2'd1, ACKED=2'd2 (2'd3 unused, recovers to IDLE).
  - MSG_HEADER=2'b10.
  - A function packing the message byte.
- Sub-module dispatch_tx: valid/ready holding register with pending merge and one-cycle gap. Inputs trigger and snapshot byte; outputs valid and data.

Test Plan (ACK_TIMEOUT=20, SIREN_HALF=4 unless noted):
- Reset, then fire_alarm=4'b0100 for one cycle -> state=ALARM, zone_latched=4'b0100, siren high 4 cycles, low 4, high 4; no dispatch.
- Alarm entered, ack=0 for 20 cycles, dispatch_ready=1 -> dispatch_valid high exactly 1 cycle, data=8'b1001_0100; ack then -> ACKED, siren=0, strobe=1.
- call=1 with fire_alarm=4'b0011, dispatch_ready=0 for 5 cycles -> valid held with data=8'b1010_0011 stable; fire_alarm=4'b1000 meanwhile sets pending. After ready -> gap cycle, then data=8'b1010_1011.
- ACKED, clear=1 with fire_alarm=4'b0001 -> ignored. fire_alarm=0 and clear=1 -> IDLE, zone_latched=0, strobe=0.
- ack and timeout on the same edge -> ACKED, escalated=0, no message.
- With FIRE_RESP_REALERT_EN: ACKED and new zone 4'b0010 -> ALARM, siren restarts high. Without the macro -> stays ACKED, siren=0.
